// File: rtl/vending_controller_multi.sv
// Multi-product vending controller: accumulates coin credit, checks each
// purchase against a price table and per-product stock, times the dispense
// pulse, supports repeat purchases and refunds on cancel or idle timeout.
// Ports: clk, reset (async, active-high); coin_valid/coin_value,
//   product_select, buy_req, buy_more, cancel, restock in;
//   credit, dispense, dispensed_id, change, change_valid,
//   insufficient, sold_out, coin_reject, busy out (all registered).
module vending_controller_multi #(
    parameter int MONEY_W         = 8,
    parameter int NUM_PROD        = 4,
    parameter int SEL_W           = 2,
    parameter logic [NUM_PROD*MONEY_W-1:0] PRICES =
        {8'd100, 8'd75, 8'd50, 8'd25},
    parameter int STOCK_W         = 4,
    parameter int STOCK_INIT      = 3,
    parameter int DISPENSE_CYCLES = 2,
    parameter int TIMEOUT         = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [MONEY_W-1:0] coin_value,
    input  logic [SEL_W-1:0]   product_select,
    input  logic               buy_req,
    input  logic               buy_more,
    input  logic               cancel,
    input  logic               restock,
    output logic [MONEY_W-1:0] credit,
    output logic               dispense,
    output logic [SEL_W-1:0]   dispensed_id,
    output logic [MONEY_W-1:0] change,
    output logic               change_valid,
    output logic               insufficient,
    output logic               sold_out,
    output logic               coin_reject,
    output logic               busy
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int DC_W  = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic               dispense_q, dispense_d;
    logic [SEL_W-1:0]   id_q, id_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic               chg_vld_q, chg_vld_d;
    logic               insuf_q, insuf_d;
    logic               sold_q, sold_d;
    logic               crej_q, crej_d;
    logic               busy_q, busy_d;
    logic               more_q, more_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [DC_W-1:0]    disp_q, disp_d;
    logic [STOCK_W-1:0] stock_q [NUM_PROD];
    logic [STOCK_W-1:0] stock_d [NUM_PROD];

    logic [MONEY_W-1:0] sel_price;
    logic [STOCK_W-1:0] sel_stock;
    logic               sel_ok;
    logic [MONEY_W:0]   sum;

    // Price/stock of the selected product; out-of-range index reads as 0
    always_comb begin
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (product_select == SEL_W'(i)) begin
                sel_price = PRICES[i*MONEY_W +: MONEY_W];
                sel_stock = stock_q[i];
            end
        end
    end

    assign sel_ok = 32'(product_select) < NUM_PROD;
    // Extra carry bit detects credit overflow
    assign sum    = {1'b0, credit_q} + {1'b0, coin_value};

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        dispense_d = dispense_q;
        id_d       = id_q;
        change_d   = '0;
        chg_vld_d  = 1'b0;
        insuf_d    = 1'b0;
        sold_d     = 1'b0;
        crej_d     = 1'b0;
        busy_d     = busy_q;
        more_d     = more_q;
        tmo_d      = tmo_q;
        disp_d     = disp_q;
        stock_d    = stock_q;
        unique case (state_q)
            IDLE: begin
                if (restock)
                    for (int i = 0; i < NUM_PROD; i++)
                        stock_d[i] = STOCK_W'(STOCK_INIT);
                if (buy_req)
                    insuf_d = 1'b1;
                if (coin_valid) begin
                    credit_d = coin_value;
                    tmo_d    = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    crej_d    = coin_valid;
                    change_d  = credit_q;
                    chg_vld_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = REFUND;
                end else if (buy_req) begin
                    crej_d = coin_valid;
                    tmo_d  = '0;
                    if (!sel_ok || sel_stock == '0) begin
                        sold_d = 1'b1;
                    end else if (credit_q < sel_price) begin
                        insuf_d = 1'b1;
                    end else begin
                        credit_d   = credit_q - sel_price;
                        for (int i = 0; i < NUM_PROD; i++)
                            if (product_select == SEL_W'(i))
                                stock_d[i] = stock_q[i] - STOCK_W'(1);
                        id_d       = product_select;
                        more_d     = buy_more;
                        dispense_d = 1'b1;
                        busy_d     = 1'b1;
                        disp_d     = '0;
                        state_d    = VEND;
                    end
                end else if (coin_valid && !sum[MONEY_W]) begin
                    credit_d = sum[MONEY_W-1:0];
                    tmo_d    = '0;
                end else begin
                    crej_d = coin_valid;
                    // Refund lands TIMEOUT cycles after the last activity
                    if (tmo_q == TMO_W'(TIMEOUT - 2)) begin
                        change_d  = credit_q;
                        chg_vld_d = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = REFUND;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end
            VEND: begin
                crej_d = coin_valid;
                if (disp_q == DC_W'(DISPENSE_CYCLES - 1)) begin
                    dispense_d = 1'b0;
                    id_d       = '0;
                    if (more_q && credit_q != '0) begin
                        tmo_d   = '0;
                        busy_d  = 1'b0;
                        state_d = COLLECT;
                    end else if (credit_q != '0) begin
                        change_d  = credit_q;
                        chg_vld_d = 1'b1;
                        state_d   = REFUND;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    disp_d = disp_q + DC_W'(1);
                end
            end
            REFUND: begin
                crej_d   = coin_valid;
                credit_d = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            id_q       <= '0;
            change_q   <= '0;
            chg_vld_q  <= 1'b0;
            insuf_q    <= 1'b0;
            sold_q     <= 1'b0;
            crej_q     <= 1'b0;
            busy_q     <= 1'b0;
            more_q     <= 1'b0;
            tmo_q      <= '0;
            disp_q     <= '0;
            for (int i = 0; i < NUM_PROD; i++)
                stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            id_q       <= id_d;
            change_q   <= change_d;
            chg_vld_q  <= chg_vld_d;
            insuf_q    <= insuf_d;
            sold_q     <= sold_d;
            crej_q     <= crej_d;
            busy_q     <= busy_d;
            more_q     <= more_d;
            tmo_q      <= tmo_d;
            disp_q     <= disp_d;
            stock_q    <= stock_d;
        end
    end

    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign dispensed_id = id_q;
    assign change       = change_q;
    assign change_valid = chg_vld_q;
    assign insufficient = insuf_q;
    assign sold_out     = sold_q;
    assign coin_reject  = crej_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_controller_multi.sv
// Directed self-checking bench for vending_controller_multi
// (default parameters: prices 25/50/75/100, stock 3, 2-cycle dispense, timeout 20).
module tb_vending_controller_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic [1:0] product_select;
    logic       buy_req;
    logic       buy_more;
    logic       cancel;
    logic       restock;
    logic [7:0] credit;
    logic       dispense;
    logic [1:0] dispensed_id;
    logic [7:0] change;
    logic       change_valid;
    logic       insufficient;
    logic       sold_out;
    logic       coin_reject;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vending_controller_multi dut (
        .clk            (clk),
        .reset          (reset),
        .coin_valid     (coin_valid),
        .coin_value     (coin_value),
        .product_select (product_select),
        .buy_req        (buy_req),
        .buy_more       (buy_more),
        .cancel         (cancel),
        .restock        (restock),
        .credit         (credit),
        .dispense       (dispense),
        .dispensed_id   (dispensed_id),
        .change         (change),
        .change_valid   (change_valid),
        .insufficient   (insufficient),
        .sold_out       (sold_out),
        .coin_reject    (coin_reject),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1;
        coin_value = 8'(v);
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic buy(input int p, input logic more);
        buy_req        = 1'b1;
        product_select = 2'(p);
        buy_more       = more;
        step();
        buy_req  = 1'b0;
        buy_more = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        coin_valid = 0; coin_value = 0; product_select = 0;
        buy_req = 0; buy_more = 0; cancel = 0; restock = 0;
        step();
        step();
        check("rst_credit", credit, 0);
        check("rst_dispense", dispense, 0);
        check("rst_change_valid", change_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {insufficient, sold_out, coin_reject}, 0);
        reset = 1'b0;
        step();

        // Single coin, exact price
        coin(25);
        check("t1_credit", credit, 25);
        buy(0, 1'b0);
        check("t1_disp1", dispense, 1);
        check("t1_id", dispensed_id, 0);
        check("t1_credit0", credit, 0);
        check("t1_busy", busy, 1);
        step();
        check("t1_disp2", dispense, 1);
        step();
        check("t1_disp_end", dispense, 0);
        check("t1_no_change", change_valid, 0);
        check("t1_idle_busy", busy, 0);

        // Overpay with refund, coin during VEND rejected
        coin(50);
        coin(50);
        check("t2_credit", credit, 100);
        buy(2, 1'b0);
        check("t2_disp1", dispense, 1);
        check("t2_id", dispensed_id, 2);
        check("t2_credit", credit, 25);
        coin(5);
        check("t2_vend_coinrej", coin_reject, 1);
        check("t2_disp2", dispense, 1);
        check("t2_credit_hold", credit, 25);
        step();
        check("t2_chg_vld", change_valid, 1);
        check("t2_change", change, 25);
        check("t2_disp_end", dispense, 0);
        step();
        check("t2_chg_end", change_valid, 0);
        check("t2_change0", change, 0);
        check("t2_credit0", credit, 0);

        // Insufficient credit then cancel
        coin(25);
        buy(1, 1'b0);
        check("t3_insuf", insufficient, 1);
        check("t3_sold", sold_out, 0);
        check("t3_credit", credit, 25);
        check("t3_nodisp", dispense, 0);
        step();
        check("t3_insuf_end", insufficient, 0);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check("t3_chg_vld", change_valid, 1);
        check("t3_change", change, 25);
        step();
        check("t3_credit0", credit, 0);

        // Repeat purchase
        coin(100);
        buy(1, 1'b1);
        check("t4_disp", dispense, 1);
        check("t4_credit", credit, 50);
        step();
        step();
        check("t4_back_collect", dispense, 0);
        check("t4_no_refund", change_valid, 0);
        check("t4_busy", busy, 0);
        check("t4_credit_kept", credit, 50);
        buy(1, 1'b0);
        check("t4_disp2", dispense, 1);
        check("t4_credit0", credit, 0);
        step();
        step();
        check("t4_end", dispense, 0);
        check("t4_no_chg", change_valid, 0);
        buy(1, 1'b0);
        check("t4_idle_insuf", insufficient, 1);
        check("t4_idle_nodisp", dispense, 0);

        // Stock exhaustion, timeout refund, restock
        restock = 1'b1;
        step();
        restock = 1'b0;
        for (int n = 0; n < 3; n++) begin
            coin(25);
            buy(0, 1'b0);
            check("t5_vend", dispense, 1);
            step();
            step();
        end
        coin(25);
        buy(0, 1'b0);
        check("t5_soldout", sold_out, 1);
        check("t5_not_insuf", insufficient, 0);
        check("t5_nodisp", dispense, 0);
        check("t5_credit", credit, 25);
        for (int n = 0; n < 18; n++) step();
        check("t5_tmo_early", change_valid, 0);
        step();
        check("t5_tmo_refund", change_valid, 1);
        check("t5_tmo_change", change, 25);
        step();
        restock = 1'b1;
        step();
        restock = 1'b0;
        coin(25);
        buy(0, 1'b0);
        check("t5_restocked", dispense, 1);
        step();
        step();

        // Overflow, collision, reset during VEND
        coin(250);
        check("t6_credit", credit, 250);
        coin(10);
        check("t6_ovf_rej", coin_reject, 1);
        check("t6_ovf_credit", credit, 250);
        coin_valid = 1'b1;
        coin_value = 8'd5;
        buy(3, 1'b0);
        coin_valid = 1'b0;
        coin_value = '0;
        check("t6_coll_rej", coin_reject, 1);
        check("t6_coll_disp", dispense, 1);
        check("t6_coll_credit", credit, 150);
        reset = 1'b1;
        #1;
        check("t6_rst_disp", dispense, 0);
        check("t6_rst_credit", credit, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rej", coin_reject, 0);
        step();
        reset = 1'b0;
        step();
        check("t6_post_chg", change_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
